// File: rtl/lookup_inversemapping_table_pipe_if.sv
// Descriptor, result and flow-table RAM signals of the inverse-mapping lookup.
// Handshakes: a descriptor transfers on a cycle where i_descriptor_wr and o_descriptor_ready are both 1; o_descriptor_wr is a one-cycle result strobe; the RAM returns data RD_LAT cycles after o_regroup_ram_rd.
interface lookup_inversemapping_table_pipe_if #(
  parameter int KEY_W   = 14,
  parameter int DATA_W  = 48,
  parameter int BUFID_W = 9,
  parameter int ADDR_W  = 8
);
  logic [KEY_W+BUFID_W:0] iv_descriptor;
  logic                   i_descriptor_wr;
  logic                   o_descriptor_ready;
  logic [KEY_W+DATA_W:0]  iv_regroup_ram_rdata;
  logic                   o_regroup_ram_rd;
  logic [ADDR_W-1:0]      ov_regroup_ram_raddr;
  logic [DATA_W-1:0]      ov_dmac;
  logic [BUFID_W-1:0]     ov_bufid;
  logic                   o_dmac_replace_flag;
  logic                   o_lookup_table_match_flag;
  logic                   o_descriptor_wr;
  logic                   i_descriptor_ready;

  modport slave (
    input  iv_descriptor, i_descriptor_wr, iv_regroup_ram_rdata, i_descriptor_ready,
    output o_descriptor_ready, o_regroup_ram_rd, ov_regroup_ram_raddr, ov_dmac,
           ov_bufid, o_dmac_replace_flag, o_lookup_table_match_flag, o_descriptor_wr
  );

  modport master (
    output iv_descriptor, i_descriptor_wr, iv_regroup_ram_rdata, i_descriptor_ready,
    input  o_descriptor_ready, o_regroup_ram_rd, ov_regroup_ram_raddr, ov_dmac,
           ov_bufid, o_dmac_replace_flag, o_lookup_table_match_flag, o_descriptor_wr
  );
endinterface

// File: rtl/lookup_inversemapping_table_pipe.sv
// Sequential flow-table search returning the DMAC for a descriptor's flowid.
// One RAM read per cycle; a tag pipeline matches returned data to its address for any RD_LAT.
module lookup_inversemapping_table_pipe #(
  parameter int KEY_W   = 14,
  parameter int DATA_W  = 48,
  parameter int BUFID_W = 9,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  lookup_inversemapping_table_pipe_if.slave bus,
  input  logic                  i_cnt_clear,
  output logic [CNT_W-1:0]      ov_hit_cnt,
  output logic [CNT_W-1:0]      ov_miss_cnt,
  output logic                  state_dbg
);

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [KEY_W-1:0]     key_q;
  logic [BUFID_W-1:0]   bufid_q;
  logic [ADDR_W-1:0]    issue_addr;
  logic                 issuing;
  logic [RD_LAT-1:0]    tag_v;
  logic [ADDR_W-1:0]    tag_a [RD_LAT];

  logic                 desc_req;
  logic [KEY_W-1:0]     desc_key;
  logic [BUFID_W-1:0]   desc_bufid;
  logic                 accept;
  logic                 rd;
  logic [ADDR_W-1:0]    raddr;
  logic                 ret_v;
  logic                 ent_v;
  logic [KEY_W-1:0]     ent_key;
  logic [DATA_W-1:0]    ent_dmac;
  logic                 hit;
  logic                 miss;
  logic                 term;

  assign desc_req   = bus.iv_descriptor[KEY_W+BUFID_W];
  assign desc_key   = bus.iv_descriptor[KEY_W+BUFID_W-1:BUFID_W];
  assign desc_bufid = bus.iv_descriptor[BUFID_W-1:0];
  assign ent_v      = bus.iv_regroup_ram_rdata[KEY_W+DATA_W];
  assign ent_key    = bus.iv_regroup_ram_rdata[KEY_W+DATA_W-1:DATA_W];
  assign ent_dmac   = bus.iv_regroup_ram_rdata[DATA_W-1:0];

  assign bus.o_descriptor_ready = bus.i_descriptor_ready & (state == IDLE);
  assign accept    = bus.i_descriptor_wr & bus.o_descriptor_ready;
  assign state_dbg = (state == SEARCH);

  assign rd    = (state == SEARCH) & issuing;
  assign raddr = rd ? issue_addr : '0;
  assign bus.o_regroup_ram_rd     = rd;
  assign bus.ov_regroup_ram_raddr = raddr;

  // An invalid entry ends the search before the key is even compared.
  assign ret_v = (state == SEARCH) & tag_v[RD_LAT-1];
  assign hit   = ret_v & ent_v & (ent_key == key_q);
  assign miss  = ret_v & (~ent_v | (~hit & (tag_a[RD_LAT-1] == {ADDR_W{1'b1}})));
  assign term  = hit | miss;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && desc_req) state_nxt = SEARCH;
      SEARCH:  if (term) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      issuing    <= 1'b0;
      issue_addr <= '0;
      key_q      <= '0;
      bufid_q    <= '0;
    end else if (accept && desc_req) begin
      issuing    <= 1'b1;
      issue_addr <= '0;
      key_q      <= desc_key;
      bufid_q    <= desc_bufid;
    end else if (term) begin
      issuing    <= 1'b0;
      issue_addr <= '0;
    end else if (rd) begin
      if (issue_addr == {ADDR_W{1'b1}}) issuing <= 1'b0;
      else                              issue_addr <= issue_addr + 1'b1;
    end
  end

  // Clearing the valid tags on termination makes the trailing returns harmless.
  always_ff @(posedge i_clk) begin
    if (i_rst || term) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= rd;
      for (int i = 1; i < RD_LAT; i++) tag_v[i] <= tag_v[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    tag_a[0] <= raddr;
    for (int i = 1; i < RD_LAT; i++) tag_a[i] <= tag_a[i-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_descriptor_wr           <= 1'b0;
      bus.ov_dmac                   <= '0;
      bus.ov_bufid                  <= '0;
      bus.o_lookup_table_match_flag <= 1'b0;
      bus.o_dmac_replace_flag       <= 1'b0;
    end else begin
      bus.o_descriptor_wr <= 1'b0;
      if (accept && !desc_req) begin
        bus.o_descriptor_wr           <= 1'b1;
        bus.ov_dmac                   <= '0;
        bus.ov_bufid                  <= desc_bufid;
        bus.o_lookup_table_match_flag <= 1'b1;
        bus.o_dmac_replace_flag       <= 1'b0;
      end else if (term) begin
        bus.o_descriptor_wr           <= 1'b1;
        bus.ov_dmac                   <= hit ? ent_dmac : '0;
        bus.ov_bufid                  <= bufid_q;
        bus.o_lookup_table_match_flag <= hit;
        bus.o_dmac_replace_flag       <= hit;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clear) begin
      ov_hit_cnt  <= '0;
      ov_miss_cnt <= '0;
    end else if (hit) begin
      ov_hit_cnt  <= ov_hit_cnt + 1'b1;
    end else if (miss) begin
      ov_miss_cnt <= ov_miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lookup_inversemapping_table_pipe.sv
// Bench for the inverse-mapping lookup: RAM model with RD_LAT delay, table-scan reference model.
// Result latency is derived as 2+k+RD_LAT from the entry k where the scan stops.
module tb_lookup_inversemapping_table_pipe;
  localparam int KEY_W = 14, DATA_W = 48, BUFID_W = 9, ADDR_W = 3, RD_LAT = 3, CNT_W = 16;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int EW = 1 + KEY_W + DATA_W;
  localparam int XW = 16 + 1 + 1 + DATA_W + BUFID_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cnt_clear = 1'b0;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic state_dbg;

  lookup_inversemapping_table_pipe_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .BUFID_W(BUFID_W), .ADDR_W(ADDR_W)) bus ();

  lookup_inversemapping_table_pipe #(
    .KEY_W(KEY_W), .DATA_W(DATA_W), .BUFID_W(BUFID_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus), .i_cnt_clear(cnt_clear),
    .ov_hit_cnt(hit_cnt), .ov_miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data for the address issued in cycle t appears in cycle t+RD_LAT
  logic [EW-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] ap [RD_LAT];
  always @(posedge clk) begin
    ap[0] <= bus.ov_regroup_ram_raddr;
    for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
  end
  assign bus.iv_regroup_ram_rdata = ram[ap[RD_LAT-1]];

  int rd_cnt = 0;
  logic [ADDR_W-1:0] rd_log [$];
  always @(negedge clk) if (bus.o_regroup_ram_rd) begin
    rd_cnt = rd_cnt + 1;
    rd_log.push_back(bus.ov_regroup_ram_raddr);
  end

  // scoreboard
  int n_checks = 0, n_pass = 0;
  logic [XW-1:0] exp_q [$];
  int hit_m = 0, miss_m = 0;

  function automatic logic [EW-1:0] mk(input bit v, input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d);
    return {v, k, d};
  endfunction

  task automatic clear_table();
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
  endtask

  // Reference: scan from entry 0; stop at first invalid entry, first key match, or the last entry.
  task automatic ref_search(input logic [KEY_W-1:0] key, output bit hit, output int k, output logic [DATA_W-1:0] dmac);
    logic [EW-1:0] e;
    hit = 0; k = DEPTH - 1; dmac = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = ram[i];
      if (!e[EW-1]) begin k = i; break; end
      if (e[EW-2 -: KEY_W] == key) begin hit = 1; k = i; dmac = e[DATA_W-1:0]; break; end
    end
  endtask

  // driver: present one descriptor at a negedge with ready high, then follow it to its result
  task automatic run_desc(input bit req, input logic [KEY_W-1:0] key, input logic [BUFID_W-1:0] bufid,
                          input bit do_clear, input bit chain, input string name);
    bit hit; int k; int lat; int c0; int g; bit got;
    logic [DATA_W-1:0] dm; logic [XW-1:0] e;
    logic [15:0] e_lat; logic e_match, e_repl; logic [DATA_W-1:0] e_dmac; logic [BUFID_W-1:0] e_bufid;
    if (req) begin
      ref_search(key, hit, k, dm);
      lat = 2 + k + RD_LAT;
      exp_q.push_back({16'(lat), hit, hit, dm, bufid});
      if (do_clear) begin hit_m = 0; miss_m = 0; end
      else if (hit) hit_m = hit_m + 1;
      else miss_m = miss_m + 1;
    end else begin
      lat = 1;
      exp_q.push_back({16'(lat), 1'b1, 1'b0, {DATA_W{1'b0}}, bufid});
    end
    g = 0;
    while (!bus.o_descriptor_ready && g < 100) begin @(negedge clk); g++; end
    n_checks++;
    if (!bus.o_descriptor_ready) $display("FAIL %s ready_timeout got=%0b exp=1", name, bus.o_descriptor_ready);
    else n_pass++;
    bus.iv_descriptor = {req, key, bufid};
    bus.i_descriptor_wr = 1'b1;
    c0 = cyc;
    got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (n == 0) bus.i_descriptor_wr = 1'b0;
      cnt_clear = (do_clear && cyc == c0 + lat - 1);
      if (bus.o_descriptor_wr) begin got = 1; break; end
    end
    cnt_clear = 1'b0;
    e = exp_q.pop_front();
    {e_lat, e_match, e_repl, e_dmac, e_bufid} = e;
    n_checks++;
    if (!got) $display("FAIL %s result_timeout got=none exp=cycle %0d", name, e_lat);
    else n_pass++;
    if (got) begin
      n_checks++; if (16'(cyc - c0) !== e_lat) $display("FAIL %s latency got=%0d exp=%0d", name, cyc - c0, e_lat); else n_pass++;
      n_checks++; if (bus.ov_dmac !== e_dmac) $display("FAIL %s dmac got=%h exp=%h", name, bus.ov_dmac, e_dmac); else n_pass++;
      n_checks++; if (bus.ov_bufid !== e_bufid) $display("FAIL %s bufid got=%h exp=%h", name, bus.ov_bufid, e_bufid); else n_pass++;
      n_checks++; if (bus.o_lookup_table_match_flag !== e_match) $display("FAIL %s match got=%0b exp=%0b", name, bus.o_lookup_table_match_flag, e_match); else n_pass++;
      n_checks++; if (bus.o_dmac_replace_flag !== e_repl) $display("FAIL %s replace got=%0b exp=%0b", name, bus.o_dmac_replace_flag, e_repl); else n_pass++;
      n_checks++; if (hit_cnt !== CNT_W'(hit_m)) $display("FAIL %s hit_cnt got=%0d exp=%0d", name, hit_cnt, hit_m); else n_pass++;
      n_checks++; if (miss_cnt !== CNT_W'(miss_m)) $display("FAIL %s miss_cnt got=%0d exp=%0d", name, miss_cnt, miss_m); else n_pass++;
    end
    if (!chain) begin
      @(negedge clk);
      n_checks++; if (bus.o_descriptor_wr !== 1'b0) $display("FAIL %s wr_single got=%0b exp=0", name, bus.o_descriptor_wr); else n_pass++;
      n_checks++; if (bus.ov_bufid !== e_bufid) $display("FAIL %s bufid_hold got=%h exp=%h", name, bus.ov_bufid, e_bufid); else n_pass++;
    end
  endtask

  task automatic test_reset();
    bus.i_descriptor_ready = 1'b0;
    bus.i_descriptor_wr = 1'b0;
    bus.iv_descriptor = '0;
    clear_table();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_descriptor_wr !== 1'b0) $display("FAIL reset_wr got=%0b exp=0", bus.o_descriptor_wr); else n_pass++;
    n_checks++; if (bus.ov_dmac !== '0) $display("FAIL reset_dmac got=%h exp=0", bus.ov_dmac); else n_pass++;
    n_checks++; if (bus.o_regroup_ram_rd !== 1'b0) $display("FAIL reset_rd got=%0b exp=0", bus.o_regroup_ram_rd); else n_pass++;
    n_checks++; if ({bus.o_lookup_table_match_flag, bus.o_dmac_replace_flag} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {bus.o_lookup_table_match_flag, bus.o_dmac_replace_flag}); else n_pass++;
    n_checks++; if (bus.o_descriptor_ready !== 1'b0) $display("FAIL reset_ready_low got=%0b exp=0", bus.o_descriptor_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    bus.i_descriptor_ready = 1'b1;
    #1;
    n_checks++; if (bus.o_descriptor_ready !== 1'b1) $display("FAIL reset_ready_follow got=%0b exp=1", bus.o_descriptor_ready); else n_pass++;
    n_checks++; if ({hit_cnt, miss_cnt} !== '0) $display("FAIL reset_cnt got=%h exp=0", {hit_cnt, miss_cnt}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_hit();
    clear_table();
    ram[0] = mk(1, 14'h005, 48'hAABBCCDDEEFF);
    run_desc(1, 14'h005, 9'h01A, 0, 0, "hit_entry0");
  endtask

  task automatic test_bypass();
    int r0;
    r0 = rd_cnt;
    run_desc(0, 14'h3FF, 9'h033, 0, 0, "bypass");
    n_checks++; if (rd_cnt !== r0) $display("FAIL bypass_no_rd got=%0d exp=%0d", rd_cnt - r0, 0); else n_pass++;
  endtask

  task automatic test_early_miss();
    clear_table();
    for (int i = 0; i < 3; i++) ram[i] = mk(1, 14'(16 + i), 48'(i + 1));
    ram[4] = mk(1, 14'h077, 48'h111111111111);
    ram[5] = mk(1, 14'h077, 48'h222222222222);
    run_desc(1, 14'h077, 9'h044, 0, 0, "early_miss_invalid");
  endtask

  task automatic test_exhaust();
    bit ok;
    for (int i = 0; i < DEPTH; i++) ram[i] = mk(1, 14'(100 + i), 48'(i));
    rd_log.delete();
    run_desc(1, 14'h2AA, 9'h155, 0, 0, "exhaust_miss");
    ok = (rd_log.size() == DEPTH);
    for (int i = 0; i < rd_log.size() && ok; i++) if (rd_log[i] != ADDR_W'(i)) ok = 0;
    n_checks++; if (!ok) $display("FAIL exhaust_addr_seq got=%0d reads exp=%0d in order", rd_log.size(), DEPTH); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_table();
    ram[0] = mk(1, 14'h0A0, 48'h0000000000A0);
    ram[1] = mk(1, 14'h0B1, 48'h0000000000B1);
    ram[2] = mk(1, 14'h0C2, 48'h0000000000C2);
    for (int i = 3; i < DEPTH; i++) ram[i] = mk(1, 14'h0A0, 48'hDEAD00000000 + 48'(i));
    run_desc(1, 14'h0C2, 9'h002, 0, 1, "b2b_first");
    run_desc(1, 14'h0A0, 9'h003, 0, 0, "b2b_second");
  endtask

  task automatic test_cnt_clear();
    clear_table();
    ram[0] = mk(1, 14'h001, 48'h1);
    ram[1] = mk(1, 14'h002, 48'h123456789ABC);
    run_desc(1, 14'h002, 9'h0F0, 1, 0, "clear_on_hit");
  endtask

  task automatic test_reset_mid_search();
    int wr_seen, r0;
    for (int i = 0; i < DEPTH; i++) ram[i] = mk(1, 14'(200 + i), 48'(i));
    ram[DEPTH-1] = mk(1, 14'h155, 48'hFEEDFACECAFE);
    @(negedge clk);
    bus.iv_descriptor = {1'b1, 14'h155, 9'h0AB};
    bus.i_descriptor_wr = 1'b1;
    @(negedge clk);
    bus.i_descriptor_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hit_m = 0; miss_m = 0;
    n_checks++; if (state_dbg !== 1'b0) $display("FAIL midrst_state got=%0b exp=0", state_dbg); else n_pass++;
    n_checks++; if (bus.o_regroup_ram_rd !== 1'b0) $display("FAIL midrst_rd got=%0b exp=0", bus.o_regroup_ram_rd); else n_pass++;
    wr_seen = 0; r0 = rd_cnt;
    repeat (20) begin @(negedge clk); if (bus.o_descriptor_wr) wr_seen++; end
    n_checks++; if (wr_seen !== 0) $display("FAIL midrst_no_wr got=%0d exp=0", wr_seen); else n_pass++;
    n_checks++; if (rd_cnt !== r0) $display("FAIL midrst_no_rd got=%0d exp=0", rd_cnt - r0); else n_pass++;
    n_checks++; if (bus.ov_dmac !== '0) $display("FAIL midrst_dmac got=%h exp=0", bus.ov_dmac); else n_pass++;
    run_desc(1, 14'h155, 9'h0AC, 0, 0, "after_midrst");
  endtask

  task automatic test_random();
    bit req;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++)
        ram[i] = mk(($urandom_range(0, 7) != 0), 14'($urandom_range(1, 4)), {16'($urandom), 32'($urandom)});
      req = ($urandom_range(0, 3) != 0);
      run_desc(req, 14'($urandom_range(1, 4)), 9'($urandom_range(0, 511)), 0, 0, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_bypass();
    test_early_miss();
    test_exhaust();
    test_back_to_back();
    test_cnt_clear();
    test_reset_mid_search();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
